// File: rtl/vram_arbiter_if.sv
// Bundle of the ISA-side, display-side and SRAM-side signals around the VRAM arbiter.
interface vram_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 19
);
    logic                  isa_read;
    logic                  isa_write;
    logic [ADDR_WIDTH-1:0] isa_addr;
    logic [7:0]            isa_din;
    logic [7:0]            isa_dout;
    logic                  bus_rdy;
    logic                  slot;
    logic                  pixel_read;
    logic [ADDR_WIDTH-1:0] pixel_addr;
    logic [7:0]            pixel_data;
    logic                  pixel_valid;
    logic [ADDR_WIDTH-1:0] ram_a;
    logic [7:0]            ram_dout;
    logic                  ram_oe;
    logic [7:0]            ram_din;
    logic                  ram_we_l;

    // System side: ISA decode, sequencer, display fetch and the SRAM pins.
    modport master (
        output isa_read, isa_write, isa_addr, isa_din, slot, pixel_read, pixel_addr, ram_din,
        input  isa_dout, bus_rdy, pixel_data, pixel_valid, ram_a, ram_dout, ram_oe, ram_we_l
    );

    // Arbiter side.
    modport slave (
        input  isa_read, isa_write, isa_addr, isa_din, slot, pixel_read, pixel_addr, ram_din,
        output isa_dout, bus_rdy, pixel_data, pixel_valid, ram_a, ram_dout, ram_oe, ram_we_l
    );
endinterface

// File: rtl/vram_arbiter.sv
// Shares the single video SRAM port between display fetch (always first) and the ISA CPU.
// CPU writes are posted into a small FIFO; CPU reads stall the bus until data returns.
module vram_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 19,
    parameter int unsigned WFIFO_DEPTH  = 4,
    parameter bit          USE_BUS_WAIT = 1'b1
) (
    input logic           clk,
    input logic           rst_l,
    vram_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_REQ  = 2'd1;
    localparam logic [1:0] RD_CAP  = 2'd2;
    localparam logic [1:0] RD_DONE = 2'd3;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            data;
    } wr_entry_t;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  wr_d;
    logic                  rd_d;
    wr_entry_t             fifo [WFIFO_DEPTH];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic [CNT_W-1:0]      count;
    logic                  pend_valid;
    wr_entry_t             pend;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  pix_cap;
    logic                  bus_rdy_q;
    logic [ADDR_WIDTH-1:0] ram_a_q;
    logic [7:0]            ram_dout_q;
    logic                  ram_oe_q;
    logic                  ram_we_l_q;
    logic [7:0]            isa_dout_q;
    logic [7:0]            pixel_data_q;
    logic                  pixel_valid_q;

    logic                  wr_edge_c;
    logic                  rd_edge_c;
    logic                  full_c;
    logic                  empty_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  grant_rd_c;
    logic                  pend_set_c;
    logic                  pend_clr_c;
    logic                  pend_next_c;
    wr_entry_t             push_entry_c;

    // Edge detection, FIFO push/pop decisions, grant priority and read FSM next state.
    always_comb begin
        wr_edge_c         = bus.isa_write & ~wr_d;
        rd_edge_c         = bus.isa_read & ~rd_d;
        full_c            = (count == CNT_W'(WFIFO_DEPTH));
        empty_c           = (count == '0);
        push_c            = 1'b0;
        pend_set_c        = 1'b0;
        pend_clr_c        = 1'b0;
        push_entry_c.addr = bus.isa_addr;
        push_entry_c.data = bus.isa_din;
        state_next        = state;

        // A stalled write takes the push slot first; the CPU cannot issue another meanwhile.
        if (pend_valid) begin
            if (!full_c) begin
                push_c       = 1'b1;
                push_entry_c = pend;
                pend_clr_c   = 1'b1;
            end
        end else if (wr_edge_c) begin
            if (!full_c) begin
                push_c = 1'b1;
            end else begin
                pend_set_c = 1'b1;
            end
        end
        pend_next_c = (pend_valid & ~pend_clr_c) | pend_set_c;

        // Reads wait for every posted write (FIFO and stall register) so the CPU sees its own data.
        pop_c      = ~bus.pixel_read & bus.slot & ~empty_c;
        grant_rd_c = ~bus.pixel_read & bus.slot & empty_c & ~pend_valid & (state == RD_REQ);

        case (state)
            IDLE:    if (rd_edge_c) state_next = RD_REQ;
            RD_REQ:  if (grant_rd_c) state_next = RD_CAP;
            RD_CAP:  state_next = RD_DONE;
            RD_DONE: if (!bus.isa_read) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request edge detectors, read address latch and the stalled-write register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_d       <= 1'b0;
            rd_d       <= 1'b0;
            rd_addr    <= '0;
            pend_valid <= 1'b0;
            pend       <= '0;
        end else begin
            wr_d       <= bus.isa_write;
            rd_d       <= bus.isa_read;
            pend_valid <= pend_next_c;
            if (state == IDLE && rd_edge_c) rd_addr <= bus.isa_addr;
            if (pend_set_c) begin
                pend.addr <= bus.isa_addr;
                pend.data <= bus.isa_din;
            end
        end
    end

    // Posted-write FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_c) wptr <= wptr + PTR_W'(1);
            if (pop_c)  rptr <= rptr + PTR_W'(1);
            if (push_c && !pop_c)      count <= count + CNT_W'(1);
            else if (pop_c && !push_c) count <= count - CNT_W'(1);
        end
    end

    // Posted-write FIFO storage; contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
        if (push_c) fifo[wptr] <= push_entry_c;
    end

    // SRAM port, display return data, CPU read data and ISA ready.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ram_a_q       <= '0;
            ram_dout_q    <= '0;
            ram_oe_q      <= 1'b0;
            ram_we_l_q    <= 1'b1;
            pix_cap       <= 1'b0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            isa_dout_q    <= '0;
            bus_rdy_q     <= 1'b1;
        end else begin
            ram_we_l_q    <= 1'b1;
            ram_oe_q      <= 1'b0;
            pix_cap       <= 1'b0;
            pixel_valid_q <= pix_cap;
            if (pix_cap) pixel_data_q <= bus.ram_din;
            if (bus.pixel_read) begin
                ram_a_q <= bus.pixel_addr;
                pix_cap <= 1'b1;
            end else if (pop_c) begin
                ram_a_q    <= fifo[rptr].addr;
                ram_dout_q <= fifo[rptr].data;
                ram_oe_q   <= 1'b1;
                ram_we_l_q <= 1'b0;
            end else if (grant_rd_c) begin
                ram_a_q <= rd_addr;
            end
            if (state == RD_CAP) isa_dout_q <= bus.ram_din;
            bus_rdy_q <= ~((state_next == RD_REQ) | (state_next == RD_CAP) | pend_next_c);
        end
    end

    assign bus.ram_a       = ram_a_q;
    assign bus.ram_dout    = ram_dout_q;
    assign bus.ram_oe      = ram_oe_q;
    assign bus.ram_we_l    = ram_we_l_q;
    assign bus.pixel_data  = pixel_data_q;
    assign bus.pixel_valid = pixel_valid_q;
    assign bus.isa_dout    = isa_dout_q;
    assign bus.bus_rdy     = USE_BUS_WAIT ? bus_rdy_q : 1'b1;
endmodule
